// File: rtl/input_vc_buffer.sv
// rtl/input_vc_buffer.sv - per-input-port VC buffer: per-VC FIFOs, downstream credits, switch requests, packet state
// Optional VCBUF_ERR_CHK_EN adds sticky err_flags (overflow, protocol, credit overflow).
module input_vc_buffer #(
  parameter int NUM_VCS    = 3,
  parameter int BUF_DEPTH  = 4,
  parameter int FLIT_WIDTH = 32,
  parameter int DS_CREDITS = 4,
  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flit_in_valid,
  input  logic [FLIT_WIDTH-1:0] flit_in,
  input  logic [VW-1:0]         flit_in_vc,
  input  logic                  credit_in_valid,
  input  logic [VW-1:0]         credit_in_vc,
  output logic [NUM_VCS-1:0]    requests,
  input  logic [NUM_VCS-1:0]    grants,
  output logic                  flit_out_valid,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic [VW-1:0]         flit_out_vc,
  output logic                  credit_out_valid,
  output logic [VW-1:0]         credit_out_vc,
  output logic [NUM_VCS-1:0]    vc_busy
`ifdef VCBUF_ERR_CHK_EN
  , output logic [2:0]          err_flags
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int KW = $clog2(DS_CREDITS + 1);

  localparam logic [1:0] T_BODY      = 2'b00;
  localparam logic [1:0] T_HEAD      = 2'b01;
  localparam logic [1:0] T_TAIL      = 2'b10;
  localparam logic [1:0] T_HEAD_TAIL = 2'b11;

  typedef enum logic {IDLE, ACTIVE} vc_state_t;

  logic [FLIT_WIDTH-1:0] mem [NUM_VCS][BUF_DEPTH];
  logic [PW-1:0]         rd_ptr [NUM_VCS];
  logic [PW-1:0]         wr_ptr [NUM_VCS];
  logic [CW-1:0]         count  [NUM_VCS];
  logic [KW-1:0]         credit [NUM_VCS];
  vc_state_t             st     [NUM_VCS];

  logic                  found;
  logic                  pop;
  logic [VW-1:0]         gsel;
  logic [FLIT_WIDTH-1:0] head_flit;
  logic [1:0]            ftype;
  logic [NUM_VCS-1:0]    pop_v;
  logic [NUM_VCS-1:0]    push_req;
  logic [NUM_VCS-1:0]    push_ok;
  logic [NUM_VCS-1:0]    inc_req;

  // Only the lowest set grant bit is considered; it is honoured only if that VC requests.
  always_comb begin
    requests = '0;
    vc_busy  = '0;
    found    = 1'b0;
    gsel     = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      requests[v] = (count[v] != '0) && (credit[v] != '0);
      vc_busy[v]  = (st[v] == ACTIVE);
      if (!found && grants[v]) begin
        found = 1'b1;
        gsel  = VW'(v);
      end
    end
    pop       = found && requests[gsel];
    head_flit = mem[gsel][rd_ptr[gsel]];
    ftype     = head_flit[FLIT_WIDTH-1 -: 2];
    pop_v     = '0;
    push_req  = '0;
    push_ok   = '0;
    inc_req   = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      pop_v[v]    = pop && (gsel == VW'(v));
      push_req[v] = flit_in_valid && (flit_in_vc == VW'(v));
      push_ok[v]  = push_req[v] && ((count[v] < CW'(BUF_DEPTH)) || pop_v[v]);
      inc_req[v]  = credit_in_valid && (credit_in_vc == VW'(v));
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (push_ok[v]) mem[v][wr_ptr[v]] <= flit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flit_out_valid   <= 1'b0;
      flit_out         <= '0;
      flit_out_vc      <= '0;
      credit_out_valid <= 1'b0;
      credit_out_vc    <= '0;
      for (int v = 0; v < NUM_VCS; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v]  <= '0;
        credit[v] <= KW'(DS_CREDITS);
        st[v]     <= IDLE;
      end
    end else begin
      flit_out_valid   <= pop;
      credit_out_valid <= pop;
      if (pop) begin
        flit_out      <= head_flit;
        flit_out_vc   <= gsel;
        credit_out_vc <= gsel;
      end
      for (int v = 0; v < NUM_VCS; v++) begin
        if (push_ok[v])
          wr_ptr[v] <= (wr_ptr[v] == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr[v] + 1'b1;
        if (pop_v[v])
          rd_ptr[v] <= (rd_ptr[v] == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr[v] + 1'b1;
        case ({push_ok[v], pop_v[v]})
          2'b10:   count[v] <= count[v] + 1'b1;
          2'b01:   count[v] <= count[v] - 1'b1;
          default: count[v] <= count[v];
        endcase
        // A return and a pop on the same VC cancel, even at the saturation limit.
        if (inc_req[v] && !pop_v[v] && credit[v] < KW'(DS_CREDITS))
          credit[v] <= credit[v] + 1'b1;
        else if (pop_v[v] && !inc_req[v])
          credit[v] <= credit[v] - 1'b1;
        if (pop_v[v]) begin
          case (ftype)
            T_HEAD:  if (st[v] == IDLE) st[v] <= ACTIVE;
            T_TAIL:  if (st[v] == ACTIVE) st[v] <= IDLE;
            default: st[v] <= st[v];
          endcase
        end
      end
    end
  end

`ifdef VCBUF_ERR_CHK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_flags <= '0;
    end else begin
      if (|(push_req & ~push_ok)) err_flags[0] <= 1'b1;
      if (pop && (((ftype == T_HEAD) && (st[gsel] == ACTIVE)) ||
                  (((ftype == T_BODY) || (ftype == T_TAIL)) && (st[gsel] == IDLE))))
        err_flags[1] <= 1'b1;
      for (int v = 0; v < NUM_VCS; v++) begin
        if (inc_req[v] && !pop_v[v] && credit[v] == KW'(DS_CREDITS)) err_flags[2] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_input_vc_buffer.sv
// tb/tb_input_vc_buffer.sv - directed self-checking bench for input_vc_buffer
module tb_input_vc_buffer;

  localparam logic [1:0] T_BODY      = 2'b00;
  localparam logic [1:0] T_HEAD      = 2'b01;
  localparam logic [1:0] T_TAIL      = 2'b10;
  localparam logic [1:0] T_HEAD_TAIL = 2'b11;

  logic        clk;
  logic        reset;
  logic        flit_in_valid;
  logic [31:0] flit_in;
  logic [1:0]  flit_in_vc;
  logic        credit_in_valid;
  logic [1:0]  credit_in_vc;
  logic [2:0]  requests;
  logic [2:0]  grants;
  logic        flit_out_valid;
  logic [31:0] flit_out;
  logic [1:0]  flit_out_vc;
  logic        credit_out_valid;
  logic [1:0]  credit_out_vc;
  logic [2:0]  vc_busy;
`ifdef VCBUF_ERR_CHK_EN
  logic [2:0]  err_flags;
`endif

  int n_checks = 0;
  int n_errors = 0;

  input_vc_buffer #(.NUM_VCS(3), .BUF_DEPTH(4), .FLIT_WIDTH(32), .DS_CREDITS(4)) dut (
    .clk(clk), .reset(reset),
    .flit_in_valid(flit_in_valid), .flit_in(flit_in), .flit_in_vc(flit_in_vc),
    .credit_in_valid(credit_in_valid), .credit_in_vc(credit_in_vc),
    .requests(requests), .grants(grants),
    .flit_out_valid(flit_out_valid), .flit_out(flit_out), .flit_out_vc(flit_out_vc),
    .credit_out_valid(credit_out_valid), .credit_out_vc(credit_out_vc),
    .vc_busy(vc_busy)
`ifdef VCBUF_ERR_CHK_EN
    , .err_flags(err_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] vc, input logic [31:0] f);
    flit_in_valid = 1'b1; flit_in_vc = vc; flit_in = f;
    tick();
    flit_in_valid = 1'b0;
  endtask

  task automatic credit(input logic [1:0] vc);
    credit_in_valid = 1'b1; credit_in_vc = vc;
    tick();
    credit_in_valid = 1'b0;
  endtask

  task automatic grant_exp(input string tag, input logic [2:0] g, input logic [1:0] vc, input logic [31:0] f);
    grants = g;
    tick();
    grants = '0;
    check({tag, "_valid"}, flit_out_valid, 1'b1);
    check({tag, "_flit"}, flit_out, f);
    check({tag, "_vc"}, flit_out_vc, vc);
    check({tag, "_cvalid"}, credit_out_valid, 1'b1);
    check({tag, "_cvc"}, credit_out_vc, vc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, requests, 3'b000);
    check({tag, "_fov"}, flit_out_valid, 1'b0);
    check({tag, "_fo"}, flit_out, 32'h0);
    check({tag, "_fovc"}, flit_out_vc, 2'd0);
    check({tag, "_cov"}, credit_out_valid, 1'b0);
    check({tag, "_covc"}, credit_out_vc, 2'd0);
    check({tag, "_busy"}, vc_busy, 3'b000);
  endtask

  initial begin
    reset = 1'b1; flit_in_valid = 1'b0; flit_in = '0; flit_in_vc = '0;
    credit_in_valid = 1'b0; credit_in_vc = '0; grants = '0;
    repeat (2) tick();
    check_all_zero("reset");
`ifdef VCBUF_ERR_CHK_EN
    check("reset_err", err_flags, 3'b000);
`endif
    reset = 1'b0;
    tick();

    // single HEAD_TAIL on VC1
    push(2'd1, mk(T_HEAD_TAIL, 30'h11));
    check("t1_req", requests, 3'b010);
    grant_exp("t1_pop", 3'b010, 2'd1, mk(T_HEAD_TAIL, 30'h11));
    check("t1_req_after", requests, 3'b000);
    check("t1_busy", vc_busy, 3'b000);
    grants = 3'b100;
    tick();
    grants = '0;
    check("t1_ignored_grant", flit_out_valid, 1'b0);

    // HEAD/BODY/TAIL packet on VC0
    push(2'd0, mk(T_HEAD, 30'hA));
    push(2'd0, mk(T_BODY, 30'hB));
    push(2'd0, mk(T_TAIL, 30'hC));
    grant_exp("t2_head", 3'b001, 2'd0, mk(T_HEAD, 30'hA));
    check("t2_busy_head", vc_busy, 3'b001);
    grant_exp("t2_body", 3'b001, 2'd0, mk(T_BODY, 30'hB));
    check("t2_busy_body", vc_busy, 3'b001);
    grant_exp("t2_tail", 3'b001, 2'd0, mk(T_TAIL, 30'hC));
    check("t2_busy_tail", vc_busy, 3'b000);

    // multi-hot grant takes the lowest index; credit0 drops to 0, credit1 to 2
    push(2'd0, mk(T_HEAD_TAIL, 30'h40));
    push(2'd1, mk(T_HEAD_TAIL, 30'h41));
    grant_exp("mh_low", 3'b011, 2'd0, mk(T_HEAD_TAIL, 30'h40));
    check("mh_req", requests, 3'b010);
    grant_exp("mh_next", 3'b010, 2'd1, mk(T_HEAD_TAIL, 30'h41));
    for (int i = 0; i < 5; i++) credit(2'd0);

    // overflow on VC2
    for (int i = 0; i < 5; i++) push(2'd2, mk(T_HEAD_TAIL, 30'h20 + 30'(i)));
    check("t3_req", requests, 3'b100);
`ifdef VCBUF_ERR_CHK_EN
    check("t3_err_ovf", err_flags[0], 1'b1);
`endif
    for (int i = 0; i < 4; i++)
      grant_exp("t3_pop", 3'b100, 2'd2, mk(T_HEAD_TAIL, 30'h20 + 30'(i)));
    check("t3_empty", requests, 3'b000);

    // exhaust VC0 credits (saturated at 4 above)
    for (int i = 0; i < 4; i++) push(2'd0, mk(T_HEAD_TAIL, 30'h30 + 30'(i)));
    for (int i = 0; i < 4; i++)
      grant_exp("t4_pop", 3'b001, 2'd0, mk(T_HEAD_TAIL, 30'h30 + 30'(i)));
    push(2'd0, mk(T_HEAD_TAIL, 30'h34));
    push(2'd0, mk(T_HEAD_TAIL, 30'h35));
    check("t4_no_credit", requests, 3'b000);
    credit(2'd0);
    check("t4_credit_back", requests, 3'b001);
    grant_exp("t4_pop34", 3'b001, 2'd0, mk(T_HEAD_TAIL, 30'h34));
    check("t4_no_credit2", requests, 3'b000);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) credit(2'd0);
    for (int i = 0; i < 3; i++) push(2'd0, mk(T_HEAD_TAIL, 30'h36 + 30'(i)));
    flit_in_valid = 1'b1; flit_in_vc = 2'd0; flit_in = mk(T_HEAD_TAIL, 30'h39);
    grant_exp("t5_pushpop", 3'b001, 2'd0, mk(T_HEAD_TAIL, 30'h35));
    flit_in_valid = 1'b0;
    push(2'd0, mk(T_HEAD_TAIL, 30'h50));
    credit_in_valid = 1'b1; credit_in_vc = 2'd0;
    grant_exp("t5_pop36", 3'b001, 2'd0, mk(T_HEAD_TAIL, 30'h36));
    credit_in_valid = 1'b0;
    for (int i = 0; i < 3; i++)
      grant_exp("t5_pop", 3'b001, 2'd0, mk(T_HEAD_TAIL, 30'h37 + 30'(i)));
    check("t5_empty", requests, 3'b000);
    push(2'd0, mk(T_HEAD_TAIL, 30'h40));
    check("t5_credit_zero", requests, 3'b000);

    // reset while VC1 is mid-packet with 3 flits queued
    push(2'd1, mk(T_HEAD, 30'h60));
    for (int i = 0; i < 3; i++) push(2'd1, mk(T_BODY, 30'h61 + 30'(i)));
    grant_exp("t6_head", 3'b010, 2'd1, mk(T_HEAD, 30'h60));
    check("t6_busy", vc_busy, 3'b010);
    reset = 1'b1;
    tick();
    check_all_zero("t6_reset");
`ifdef VCBUF_ERR_CHK_EN
    check("t6_err", err_flags, 3'b000);
`endif
    reset = 1'b0;
    tick();
    check("t6_req_idle", requests, 3'b000);
    for (int i = 0; i < 4; i++) push(2'd1, mk(T_HEAD_TAIL, 30'h70 + 30'(i)));
    for (int i = 0; i < 4; i++)
      grant_exp("t6_pop", 3'b010, 2'd1, mk(T_HEAD_TAIL, 30'h70 + 30'(i)));
    check("t6_end_req", requests, 3'b000);
    check("t6_end_busy", vc_busy, 3'b000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/input_vc_buffer.md
Name: input_vc_buffer

Overview:
Per-input-port virtual-channel buffer for the VC router. It stores incoming flits in one FIFO per VC and tracks downstream credits per VC. From these it drives the per-VC request vector into the switch-allocation arbiter (arbiter_top, NUM_REQS = NUM_VCS), and dequeues the granted VC's head flit toward the crossbar. It also returns upstream credits and tracks per-VC packet state.

Parameters:
NUM_VCS, 3, number of virtual channels; equals arbiter NUM_REQS.
BUF_DEPTH, 4, flit slots per VC FIFO; must be >= 2.
FLIT_WIDTH, 32, flit width in bits; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] hold the flit type.
DS_CREDITS, 4, initial and maximum downstream credits per VC.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
flit_in_valid  input  1  incoming flit valid.
flit_in  input  FLIT_WIDTH  incoming flit.
flit_in_vc  input  $clog2(NUM_VCS)  target VC of the incoming flit.
credit_in_valid  input  1  downstream returned one credit.
credit_in_vc  input  $clog2(NUM_VCS)  VC of the returned credit.
requests  output  NUM_VCS  per-VC request to the arbiter.
grants  input  NUM_VCS  one-hot grant from the arbiter.
flit_out_valid  output  1  dequeued flit valid.
flit_out  output  FLIT_WIDTH  dequeued flit.
flit_out_vc  output  $clog2(NUM_VCS)  VC of the dequeued flit.
credit_out_valid  output  1  one credit returned upstream.
credit_out_vc  output  $clog2(NUM_VCS)  VC of the returned credit.
vc_busy  output  NUM_VCS  per-VC packet-in-progress state.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Flit type encoding: 00 BODY, 01 HEAD, 10 TAIL, 11 HEAD_TAIL.
- Reset state: all FIFOs empty, pointers 0, credit counters = DS_CREDITS, VC state IDLE. All outputs 0: requests, flit_out_valid, flit_out, flit_out_vc, credit_out_valid, credit_out_vc, vc_busy.
- Enqueue: when flit_in_valid is high, write to FIFO[flit_in_vc] at the clock edge.
  - Accepted if count < BUF_DEPTH, or if the same VC is popped in the same cycle.
  - Otherwise the flit is dropped and the FIFO is unchanged.
- requests[v] is combinational from registered state: FIFO[v] non-empty AND credit[v] > 0.
- Dequeue:
  - A grant bit g is honoured only if requests[g] is high. A grant on a non-requesting VC is ignored.
  - A multi-hot grant honours only the lowest set index.
  - An honoured grant pops FIFO[g] and decrements credit[g].
  - Next cycle: flit_out_valid = 1, flit_out = popped flit, flit_out_vc = g. Latency is 1 cycle from grant.
  - The pop is also reported upstream as credit_out_valid / credit_out_vc, registered in the same cycle as flit_out.
- Credits:
  - credit_in_valid increments credit[credit_in_vc], saturating at DS_CREDITS.
  - Increment and decrement on the same VC in one cycle leave the count unchanged.
  - While credit[v] = 0, requests[v] is 0.
- Per-VC state machine (updated on pop), IDLE and ACTIVE:
  - IDLE, pop HEAD: go to ACTIVE.
  - IDLE, pop HEAD_TAIL: stay IDLE.
  - ACTIVE, pop TAIL: go to IDLE.
  - ACTIVE, pop BODY: stay ACTIVE.
  - Any other combination leaves the state unchanged.
  - vc_busy[v] = 1 when VC v is ACTIVE.
- Pointers wrap modulo BUF_DEPTH. Occupancy counters are $clog2(BUF_DEPTH+1) bits wide.
- Reset mid-packet: all state is cleared on the next edge and any flits in flight are discarded.

Optional Feature:
Macro: VCBUF_ERR_CHK_EN.
- Defined: adds output err_flags [2:0], sticky, cleared only by reset.
  - bit0: overflow (enqueue dropped).
  - bit1: protocol error (pop HEAD while ACTIVE, or pop BODY/TAIL while IDLE).
  - bit2: credit overflow (increment attempted at DS_CREDITS).
- Not defined: no err_flags port and no checking logic. Overflow flits are still silently dropped.

Test Plan:
- Reset, then push HEAD_TAIL to VC1 and grant 3'b010 -> requests = 3'b010 before the grant. flit_out_valid = 1 next cycle with flit_out_vc = 1 and credit_out_vc = 1. Afterwards requests = 0 and vc_busy = 0.
- Push HEAD, BODY, TAIL to VC0 and grant each in turn -> vc_busy[0] = 1 after the HEAD pop, still 1 after BODY, 0 after the TAIL pop. Flits come out in FIFO order.
- Push 5 flits to VC2 (BUF_DEPTH = 4) with no grants -> the 5th is dropped and only 4 come out. With VCBUF_ERR_CHK_EN defined, err_flags[0] = 1.
- Grant VC0 four times with no credit_in -> credit[0] = 0 and requests[0] = 0 even with flits queued. One credit_in on VC0 -> requests[0] = 1 the next cycle.
- Full VC0 with a simultaneous push and grant -> push accepted and occupancy stays 4. Simultaneous credit_in and grant on VC0 -> credit unchanged.
- Assert reset while VC1 is ACTIVE with 3 flits queued -> next cycle all outputs are 0, vc_busy = 0 and credits = DS_CREDITS.
